// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths, buffer pacing FSM encoding, bit timing.
package uart_pkg;

    localparam int UART_DATA_WIDTH    = 8;
    localparam int UART_ADDR_WIDTH    = 4;
    localparam int UART_START_TIMEOUT = 4;
    localparam int CLKS_PER_BIT       = 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int timer_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_byte_buffer_if.sv
// Receiver-side byte strobe, transmitter handshake and buffer status bundle.
interface uart_byte_buffer_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int ADDR_WIDTH = UART_ADDR_WIDTH
) ();

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  tx_busy;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_start;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  overflow;

    modport master (
        output in_data, in_valid, tx_busy,
        input  tx_data, tx_start, count, empty, full, overflow
    );

    modport slave (
        input  in_data, in_valid, tx_busy,
        output tx_data, tx_start, count, empty, full, overflow
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered occupancy flags and a sticky overflow flag.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int ADDR_WIDTH = UART_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);

    localparam int unsigned       DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_wr;
    logic                  do_rd;
    logic [ADDR_WIDTH:0]   count_next;

    // Full is judged on the pre-edge count, so a full FIFO drops a write even while popping.
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_wr && !do_rd) begin
            count_next = count + 1'b1;
        end else if (!do_wr && do_rd) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == FULL_COUNT);
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_byte_buffer.sv
// Elastic byte buffer between uart_receiver and uart_transmitter; launches one byte
// per transmitter frame and gives up on a start that tx_busy never acknowledges.
module uart_byte_buffer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH    = UART_DATA_WIDTH,
    parameter int ADDR_WIDTH    = UART_ADDR_WIDTH,
    parameter int START_TIMEOUT = UART_START_TIMEOUT
) (
    input logic               clock,
    input logic               reset,
    uart_byte_buffer_if.slave bus
);

    localparam int                 TIMER_W    = timer_width(START_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(START_TIMEOUT - 1);

    tx_state_t             state;
    logic [TIMER_W-1:0]    timer;
    logic                  pop;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_start_q;

    assign pop          = (state == IDLE) && !bus.empty && !bus.tx_busy;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (bus.in_valid),
        .wr_data  (bus.in_data),
        .rd_en    (pop),
        .rd_data  (fifo_rd_data),
        .count    (bus.count),
        .empty    (bus.empty),
        .full     (bus.full),
        .overflow (bus.overflow)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data_q  <= fifo_rd_data;
                        tx_start_q <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                // An unacknowledged start drops its byte; no retry.
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TIMER_LAST) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_buffer.sv
// Self-checking bench for uart_byte_buffer: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_uart_byte_buffer;
    import uart_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int TMO   = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    uart_byte_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    uart_byte_buffer #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .START_TIMEOUT (TMO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] launched[$];
    logic       m_ovf;
    logic [7:0] prev_data;
    int         cyc;
    int         last_pulse;
    bit         have_pulse;
    bit         busy_since;
    bit         auto_tx;
    int         tx_delay;
    int         tx_len;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       b;
        int         cnt;
        logic       emp;
        logic       st;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: apply current inputs, update model with the spec's rules, compare.
    task automatic cycle();
        logic       iv;
        logic [7:0] d;
        logic       b;
        int         pre;
        iv = bus.in_valid;
        d  = bus.in_data;
        b  = bus.tx_busy;
        @(posedge clock);
        #1;
        cyc++;
        pre = mq.size();
        if (b) busy_since = 1'b1;
        if (bus.tx_start === 1'b1) begin
            check("start_while_busy", 32'(b), 32'd0);
            if (pre == 0) begin
                check("start_from_empty", 32'(pre), 32'd1);
            end else begin
                check("tx_data_pop", 32'(bus.tx_data), 32'(mq[0]));
                launched.push_back(mq.pop_front());
            end
            if (have_pulse && !busy_since)
                check("restart_gap", 32'(cyc - last_pulse >= TMO + 2), 32'd1);
            have_pulse = 1'b1;
            last_pulse = cyc;
            busy_since = 1'b0;
            if (auto_tx && $urandom_range(0, 4) != 0) begin
                tx_delay = $urandom_range(0, 2);
                tx_len   = $urandom_range(1, 5);
            end
        end else begin
            check("tx_data_hold", 32'(bus.tx_data), 32'(prev_data));
        end
        prev_data = bus.tx_data;
        if (iv) begin
            if (pre < DEPTH) mq.push_back(d);
            else m_ovf = 1'b1;
        end
        check("count", 32'(bus.count), 32'(mq.size()));
        check("empty", 32'(bus.empty), 32'(mq.size() == 0));
        check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        if (auto_tx) begin
            if (tx_delay > 0) begin
                tx_delay--;
                bus.tx_busy = 1'b0;
            end else if (tx_len > 0) begin
                tx_len--;
                bus.tx_busy = 1'b1;
            end else begin
                bus.tx_busy = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.tx_busy  = 1'b0;
        mq.delete();
        m_ovf      = 1'b0;
        prev_data  = '0;
        have_pulse = 1'b0;
        busy_since = 1'b0;
        tx_delay   = 0;
        tx_len     = 0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int pulses;
        int t_a;
        int t_b;
        logic [7:0] d_a;
        logic [7:0] d_b;
        int rate;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.tx_busy  = 1'b0;
        auto_tx      = 1'b0;
        cyc          = 0;
        do_reset();

        // Single byte path plus a busy-paced second byte
        tbl[0] = '{1'b1, 8'h6A, 1'b0, 1, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b1, 8'h6A};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 8'h6A};
        tbl[3] = '{1'b1, 8'h55, 1'b1, 1, 1'b0, 1'b0, 8'h6A};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'h6A};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h6A};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b1, 8'h55};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h55};
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = tbl[i].iv;
            bus.in_data  = tbl[i].d;
            bus.tx_busy  = tbl[i].b;
            cycle();
            check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(tbl[i].cnt));
            check($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(tbl[i].emp));
            check($sformatf("vec%0d_start", i), 32'(bus.tx_start), 32'(tbl[i].st));
            check($sformatf("vec%0d_data", i), 32'(bus.tx_data), 32'(tbl[i].dat));
        end
        bus.in_valid = 1'b0;
        bus.tx_busy  = 1'b1;
        cycle();
        bus.tx_busy  = 1'b0;
        cycle();
        cycle();

        // Fill, overflow, and a dropped write on a full-FIFO pop edge
        launched.delete();
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            cycle();
        end
        bus.in_data = 8'hFF;
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_count", 32'(bus.count), 32'd16);
        check("fill_overflow", 32'(bus.overflow), 32'd1);
        bus.tx_busy  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        cycle();
        check("full_pop_start", 32'(bus.tx_start), 32'd1);
        check("full_pop_count", 32'(bus.count), 32'd15);
        bus.in_valid = 1'b0;
        auto_tx = 1'b1;
        for (int i = 0; i < 400 && !(launched.size() >= 16 && bus.count == 0); i++) cycle();
        for (int i = 0; i < 10; i++) cycle();
        check("drain_n", 32'(launched.size()), 32'd16);
        for (int i = 0; i < launched.size() && i < 16; i++)
            check($sformatf("drain_order%0d", i), 32'(launched[i]), 32'(i));
        auto_tx = 1'b0;
        bus.tx_busy = 1'b0;
        for (int i = 0; i < 10; i++) cycle();

        // Reset mid-frame in WAIT_DONE with three bytes queued
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h81;
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h90 + i);
            cycle();
        end
        bus.in_valid = 1'b0;
        cycle();
        check("pre_reset_count", 32'(bus.count), 32'd3);
        do_reset();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (bus.tx_start) pulses++;
        end
        check("post_reset_pulses", 32'(pulses), 32'd0);

        // Simultaneous write and pop at count 1
        bus.tx_busy  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h11;
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        check("simul_pre_count", 32'(bus.count), 32'd1);
        bus.tx_busy  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        cycle();
        check("simul_count", 32'(bus.count), 32'd1);
        check("simul_start", 32'(bus.tx_start), 32'd1);
        check("simul_data", 32'(bus.tx_data), 32'h11);
        bus.in_valid = 1'b0;
        bus.tx_busy  = 1'b1;
        cycle();
        cycle();
        bus.tx_busy  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20 && pulses == 0; i++) begin
            cycle();
            if (bus.tx_start) pulses++;
        end
        check("simul_next_seen", 32'(pulses), 32'd1);
        check("simul_next_data", 32'(bus.tx_data), 32'h55);
        for (int i = 0; i < 10; i++) cycle();

        // Start timeout: tx_busy never rises
        do_reset();
        pulses = 0;
        t_a = 0; t_b = 0; d_a = '0; d_b = '0;
        for (int i = 0; i < 30; i++) begin
            bus.in_valid = (i < 2);
            bus.in_data  = (i == 0) ? 8'hA3 : 8'h3C;
            cycle();
            if (bus.tx_start) begin
                if (pulses == 0) begin t_a = cyc; d_a = bus.tx_data; end
                else if (pulses == 1) begin t_b = cyc; d_b = bus.tx_data; end
                pulses++;
            end
        end
        bus.in_valid = 1'b0;
        check("tmo_pulses", 32'(pulses), 32'd2);
        check("tmo_first", 32'(d_a), 32'hA3);
        check("tmo_second", 32'(d_b), 32'h3C);
        check("tmo_gap", 32'(t_b - t_a), 32'(TMO + 2));

        // Randomized traffic against the queue model
        do_reset();
        auto_tx = 1'b1;
        for (int blk = 0; blk < 15; blk++) begin
            rate = $urandom_range(1, 6);
            for (int i = 0; i < 200; i++) begin
                bus.in_valid = ($urandom_range(1, rate) == 1);
                bus.in_data  = 8'($urandom);
                cycle();
            end
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 600 && !(mq.size() == 0 && bus.count == 0); i++) cycle();
        for (int i = 0; i < 12; i++) cycle();
        check("rand_drained", 32'(mq.size()), 32'd0);
        auto_tx = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
